// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//   APB slave exposing a 16-word register window at BASE_ADDR:
//     0x00 ID (read-only constant), 0x04-0x38 RW0-RW13, 0x3C ERRCNT
//     (read-only saturating count of error responses).
//   Each transfer is captured in its setup cycle, then held for
//   WAIT_STATES extra cycles before a one-cycle response (pready).
//
// Ports
//   hclk     : clock, all state on rising edge
//   hresetn  : asynchronous active-low reset
//   psel     : slave select
//   penable  : APB access phase
//   pwrite   : 1 = write, 0 = read
//   paddr    : byte address (captured in setup)
//   pwdata   : write data (captured in setup)
//   prdata   : read data, non-zero only during a legal read response
//   pready   : transfer complete (response cycle)
//   pslverr  : transfer error, qualified by pready
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam logic [31:0] ID_VALUE = 32'hA5B2_0001;
  localparam int          NUM_RW   = 14;
  localparam logic [2:0]  CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [15:0] errcnt_q, errcnt_d;
  logic [31:0] rw_q [NUM_RW];

  // Decode of the captured transfer; paddr is not looked at after setup.
  logic        in_resp;
  logic        addr_hit;
  logic [3:0]  word_idx;
  logic        is_rw;
  logic        xfer_err;
  logic        wr_commit;
  logic [31:0] rd_value;
  logic [NUM_RW-1:0] rw_we;

  assign in_resp  = (state_q == RESP);
  assign addr_hit = (addr_q[31:6] == BASE_ADDR[31:6]) && (addr_q[1:0] == 2'b00);
  assign word_idx = addr_q[5:2];
  assign is_rw    = (word_idx != 4'h0) && (word_idx != 4'hF);
  // Misses, unaligned addresses and writes to the read-only words all error.
  assign xfer_err = !addr_hit || (write_q && !is_rw);

  // Writes land on the edge that ends the response, and only if the master
  // is still presenting a write access phase at that point.
  assign wr_commit = in_resp && psel && penable && pwrite && write_q && addr_hit && is_rw;

  always_comb begin
    rd_value = '0;
    case (word_idx)
      4'h0:    rd_value = ID_VALUE;
      4'hF:    rd_value = {16'h0000, errcnt_q};
      default: rd_value = rw_q[word_idx - 4'd1];
    endcase
  end

  assign pready  = in_resp;
  assign pslverr = in_resp && xfer_err;
  assign prdata  = (in_resp && addr_hit && !write_q) ? rd_value : 32'h0;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    errcnt_d = errcnt_q;

    case (state_q)
      IDLE: begin
        // Setup phase; penable without psel is ignored.
        if (psel && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          write_d = pwrite;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Master dropping psel aborts the transfer silently.
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pslverr && (errcnt_q != 16'hFFFF)) begin
      errcnt_d = errcnt_q + 16'd1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      errcnt_q <= errcnt_d;
    end
  end

  // RWn lives at word index n+1.
  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw_we
    assign rw_we[gi] = wr_commit && (word_idx == 4'(gi + 1));
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < NUM_RW; i++) begin
        rw_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (rw_we[i]) begin
          rw_q[i] <= wdata_q;
        end
      end
    end
  end

endmodule
